flop_fifo_rr_sched: RTL

- Round-robin scheduler that drains N upstream flop FIFOs (pop_data/data_valid/pop interface) into one registered valid/ready output stream.
- Owns each source's pop strobe; stays on the current source for up to a configurable burst of entries, then rotates.
- Sits between per-requester flop FIFOs and a shared downstream consumer.

---
 rtl/flop_fifo_rr_sched.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/flop_fifo_rr_sched.sv
// rtl/flop_fifo_rr_sched.sv - round-robin burst scheduler draining N flop FIFOs into one registered stream
// Optional counters: define FLOP_FIFO_RR_SCHED_STATS_EN for grant_cnt / stall_cnt.
module flop_fifo_rr_sched #(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 8,
  parameter int BURST_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BURST_W-1:0]           cfg_burst,
  input  logic [NUM_SRC-1:0]           cfg_src_en,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*WIDTH-1:0]     src_data,
  output logic [NUM_SRC-1:0]           src_pop,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(NUM_SRC)-1:0]   out_src,
  input  logic                         out_ready
`ifdef FLOP_FIFO_RR_SCHED_STATS_EN
  ,
  output logic [NUM_SRC*16-1:0]        grant_cnt,
  output logic [15:0]                  stall_cnt
`endif
);

  localparam int SRC_W = $clog2(NUM_SRC);

  typedef enum logic {ARB, HOLD} state_t;

  state_t             state, state_nxt;
  logic [SRC_W-1:0]   last_grant, last_grant_nxt, rr_sel, pop_idx;
  logic [BURST_W-1:0] burst_cnt, burst_cnt_nxt, eff_burst, cnt_inc;
  logic               can_load, rr_found, owner_ok, pop_any;
  logic [NUM_SRC-1:0] src_ok;
  logic [WIDTH-1:0]   pop_data;
  int                 rr_cand;

  assign src_ok    = src_valid & cfg_src_en;
  assign can_load  = !out_valid || out_ready;
  assign eff_burst = (cfg_burst == '0) ? BURST_W'(1) : cfg_burst;
  assign cnt_inc   = burst_cnt + BURST_W'(1);
  assign owner_ok  = src_ok[last_grant];

  // Rotating-priority search: first ready source after the previous grant.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    rr_cand  = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      rr_cand = (int'(last_grant) + k) % NUM_SRC;
      if (!rr_found && src_ok[SRC_W'(rr_cand)]) begin
        rr_found = 1'b1;
        rr_sel   = SRC_W'(rr_cand);
      end
    end
  end

  // Grant FSM: ARB picks a new owner, HOLD keeps it until the burst ends or it runs dry.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    pop_any        = 1'b0;
    pop_idx        = last_grant;
    if (!rst && can_load) begin
      case (state)
        ARB: begin
          if (rr_found) begin
            pop_any        = 1'b1;
            pop_idx        = rr_sel;
            last_grant_nxt = rr_sel;
            burst_cnt_nxt  = BURST_W'(1);
            if (eff_burst > BURST_W'(1)) state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (owner_ok && (burst_cnt < eff_burst)) begin
            pop_any       = 1'b1;
            burst_cnt_nxt = cnt_inc;
            if (cnt_inc >= eff_burst) state_nxt = ARB;
          end else begin
            // Owner dry, disabled, or limit lowered below the count: release with a bubble.
            state_nxt = ARB;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  // Decode the chosen source into a one-hot pop strobe and select its data.
  always_comb begin
    src_pop  = '0;
    pop_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pop_any && (pop_idx == SRC_W'(i))) begin
        src_pop[i] = 1'b1;
        pop_data   = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      last_grant <= SRC_W'(NUM_SRC - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  // Output register: load on a pop, empty when consumed without a refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (pop_any) begin
      out_valid <= 1'b1;
      out_data  <= pop_data;
      out_src   <= pop_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FLOP_FIFO_RR_SCHED_STATS_EN
  // Saturating per-source grant counters and downstream stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_pop[i] && (grant_cnt[i*16 +: 16] != 16'hFFFF))
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
      if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
